// File: rtl/control_path_master_if.sv
// Signal bundle between host, control-path bus master and slave.
// The master modport is the FSM's view; slave is the opposite side.
interface control_path_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              rdy1;
    logic [1:0]        resp1;
    logic              split;
    logic [DATA_W-1:0] rdata_in;
    logic              start;
    logic              mwrite;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [3:0]        retries;

    modport master (
        input  req, wr, addr_in, wdata_in,
        input  rdy1, resp1, split, rdata_in,
        output start, mwrite, maddr, mwdata,
        output rdata, busy, done, err,
        output err_code, retries
    );

    modport slave (
        output req, wr, addr_in, wdata_in,
        output rdy1, resp1, split, rdata_in,
        input  start, mwrite, maddr, mwdata,
        input  rdata, busy, done, err,
        input  err_code, retries
    );
endinterface

// File: rtl/control_path_master.sv
// Bus-master FSM: issues one transfer, handles RETRY/SPLIT/ERROR
// responses and a wait timeout, reports done/err back to the host.
module control_path_master #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 15
) (
    input logic                   clk,
    input logic                   rst,
    control_path_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, BACKOFF, SPLITW, DONE, ERR
    } state_t;

    localparam logic [1:0] RSP_RETRY  = 2'b01;
    localparam logic [1:0] RSP_ERROR  = 2'b10;
    localparam logic [1:0] RSP_SPLIT  = 2'b11;
    localparam logic [1:0] EC_RETRY   = 2'b01;
    localparam logic [1:0] EC_SLAVE   = 2'b10;
    localparam logic [1:0] EC_TIMEOUT = 2'b11;
    localparam logic [7:0] TMO        = 8'(TIMEOUT);
    localparam logic [3:0] MAXR       = 4'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic              bo_q, bo_d;
    logic [3:0]        retries_q, retries_d;
    logic              mwrite_q, mwrite_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Next-state, datapath updates and Moore outputs of the next state
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bo_d       = bo_q;
        retries_d  = retries_q;
        mwrite_d   = mwrite_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    mwrite_d  = bus.wr;
                    maddr_d   = bus.addr_in;
                    mwdata_d  = bus.wdata_in;
                    retries_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.resp1 == RSP_ERROR) begin
                    err_code_d = EC_SLAVE;
                    state_d    = ERR;
                end else if (bus.resp1 == RSP_RETRY) begin
                    if (retries_q == MAXR) begin
                        err_code_d = EC_RETRY;
                        state_d    = ERR;
                    end else begin
                        retries_d = retries_q + 4'd1;
                        bo_d      = 1'b0;
                        state_d   = BACKOFF;
                    end
                end else if (bus.resp1 == RSP_SPLIT) begin
                    timer_d = '0;
                    state_d = SPLITW;
                end else if (bus.rdy1) begin
                    if (!mwrite_q) begin
                        rdata_d = bus.rdata_in;
                    end
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d == TMO) begin
                        err_code_d = EC_TIMEOUT;
                        state_d    = ERR;
                    end
                end
            end
            BACKOFF: begin
                if (bo_q) begin
                    state_d = REQ;
                end else begin
                    bo_d = 1'b1;
                end
            end
            SPLITW: begin
                if (bus.split) begin
                    state_d = REQ;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d == TMO) begin
                        err_code_d = EC_TIMEOUT;
                        state_d    = ERR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_d = (state_d == REQ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bo_q       <= 1'b0;
            retries_q  <= '0;
            mwrite_q   <= 1'b0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            rdata_q    <= '0;
            err_code_q <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bo_q       <= bo_d;
            retries_q  <= retries_d;
            mwrite_q   <= mwrite_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.start    = start_q;
    assign bus.mwrite   = mwrite_q;
    assign bus.maddr    = maddr_q;
    assign bus.mwdata   = mwdata_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.retries  = retries_q;
endmodule
